// File: rtl/mips_pkg.sv
// Shared encodings for the memory-access stage: operation codes,
// FSM states, exception causes and small operation decode helpers.
package mips_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        EXC_NONE = 2'd0,
        EXC_OVF  = 2'd1,
        EXC_ADDR = 2'd2
    } exc_cause_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SB);
    endfunction

    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] s;
        s = 2'd0;
        if (op == OP_LW || op == OP_SW) begin
            s = 2'd2;
        end else if (op == OP_LH || op == OP_LHU || op == OP_SH) begin
            s = 2'd1;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data alignment: picks the addressed lane of a read word and
// sign- or zero-extends it according to the load type.
module load_align
    import mips_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [15:0] half;
    logic [7:0]  byt;

    always_comb begin
        half = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        byt  = rdata_i[7:0];
        case (lo_i)
            2'd1:    byt = rdata_i[15:8];
            2'd2:    byt = rdata_i[23:16];
            2'd3:    byt = rdata_i[31:24];
            default: byt = rdata_i[7:0];
        endcase
    end

    always_comb begin
        data_o = rdata_i;
        case (op_i)
            OP_LH:   data_o = {{16{half[15]}}, half};
            OP_LHU:  data_o = {16'h0, half};
            OP_LB:   data_o = {{24{byt[7]}}, byt};
            OP_LBU:  data_o = {24'h0, byt};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: data-memory req/ack transaction, load alignment,
// overflow/address exceptions. MEM_ALIGN_EXC_EN enables misalignment traps.
module mem_access
    import mips_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [31:0]   ex_alures,
    input  logic          ex_overflow,
    input  logic          ex_ovf_chk,
    input  logic [3:0]    ex_mem_op,
    input  logic [DW-1:0] ex_store_data,
    input  logic [4:0]    ex_wreg,
    input  logic          ex_regwrite,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic [4:0]    wb_wreg,
    output logic          wb_regwrite,
    output logic          exc_ovf,
    output logic          exc_addr
);

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    op_q, op_d;
    logic [1:0]    lo_q, lo_d;
    logic          rw_q, rw_d;
    logic          wbv_q, wbv_d;
    logic [DW-1:0] wbd_q, wbd_d;
    logic [4:0]    wbr_q, wbr_d;
    logic          wbw_q, wbw_d;
    exc_cause_e    cause_q, cause_d;

    logic          accept;
    logic          mem;
    logic          ovf;
    logic [1:0]    sz;
    logic [31:0]   eff;
    logic [3:0]    be_a;
    logic [DW-1:0] wd_a;
    logic [31:0]   ld_data;
`ifdef MEM_ALIGN_EXC_EN
    logic          mis;
`endif

    load_align u_align (
        .op_i    (op_q),
        .lo_i    (lo_q),
        .rdata_i (dmem_rdata),
        .data_o  (ld_data)
    );

    assign ex_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = ex_valid && ex_ready;

    always_comb begin
        sz  = op_size(ex_mem_op);
        mem = is_load(ex_mem_op) || is_store(ex_mem_op);
        ovf = ex_ovf_chk && ex_overflow;
`ifdef MEM_ALIGN_EXC_EN
        mis = ((sz == 2'd2) && (ex_alures[1:0] != 2'b00)) ||
              ((sz == 2'd1) && ex_alures[0]);
        eff = ex_alures;
`else
        // Misaligned addresses are silently rounded down to the access size
        eff = ex_alures;
        if (sz == 2'd2) begin
            eff[1:0] = 2'b00;
        end else if (sz == 2'd1) begin
            eff[0] = 1'b0;
        end
`endif
        case (sz)
            2'd2:    be_a = 4'b1111;
            2'd1:    be_a = eff[1] ? 4'b1100 : 4'b0011;
            default: be_a = 4'b0001 << eff[1:0];
        endcase
        case (sz)
            2'd2:    wd_a = ex_store_data;
            2'd1:    wd_a = {2{ex_store_data[15:0]}};
            default: wd_a = {4{ex_store_data[7:0]}};
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        lo_d    = lo_q;
        rw_d    = rw_q;
        wbv_d   = 1'b0;
        wbd_d   = wbd_q;
        wbr_d   = wbr_q;
        wbw_d   = wbw_q;
        cause_d = EXC_NONE;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wbr_d = ex_wreg;
                    if (!mem) begin
                        wbv_d   = 1'b1;
                        wbd_d   = ex_alures;
                        wbw_d   = ex_regwrite && !ovf;
                        cause_d = ovf ? EXC_OVF : EXC_NONE;
                    end
`ifdef MEM_ALIGN_EXC_EN
                    else if (mis) begin
                        wbv_d   = 1'b1;
                        wbd_d   = ex_alures;
                        wbw_d   = 1'b0;
                        cause_d = EXC_ADDR;
                    end
`endif
                    else begin
                        state_d = ST_ACCESS;
                        req_d   = 1'b1;
                        we_d    = is_store(ex_mem_op);
                        addr_d  = {eff[AW-1:2], 2'b00};
                        be_d    = be_a;
                        wdata_d = wd_a;
                        op_d    = ex_mem_op;
                        lo_d    = eff[1:0];
                        rw_d    = ex_regwrite;
                    end
                end
            end
            ST_ACCESS: begin
                if (dmem_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wbv_d   = 1'b1;
                    wbd_d   = is_load(op_q) ? ld_data : '0;
                    wbw_d   = is_load(op_q) && rw_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            lo_q    <= '0;
            rw_q    <= 1'b0;
            wbv_q   <= 1'b0;
            wbd_q   <= '0;
            wbr_q   <= '0;
            wbw_q   <= 1'b0;
            cause_q <= EXC_NONE;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
            rw_q    <= rw_d;
            wbv_q   <= wbv_d;
            wbd_q   <= wbd_d;
            wbr_q   <= wbr_d;
            wbw_q   <= wbw_d;
            cause_q <= cause_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_be     = be_q;
    assign dmem_wdata  = wdata_q;
    assign wb_valid    = wbv_q;
    assign wb_data     = wbd_q;
    assign wb_wreg     = wbr_q;
    assign wb_regwrite = wbw_q;
    assign exc_ovf     = wbv_q && (cause_q == EXC_OVF);
`ifdef MEM_ALIGN_EXC_EN
    assign exc_addr    = wbv_q && (cause_q == EXC_ADDR);
`else
    assign exc_addr    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: random ops against a byte-level
// memory model, with a randomized-latency memory responder.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alures;
    logic        ex_overflow;
    logic        ex_ovf_chk;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_wreg;
    logic        ex_regwrite;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_wreg;
    logic        wb_regwrite;
    logic        exc_ovf;
    logic        exc_addr;

    mem_access dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alures     (ex_alures),
        .ex_overflow   (ex_overflow),
        .ex_ovf_chk    (ex_ovf_chk),
        .ex_mem_op     (ex_mem_op),
        .ex_store_data (ex_store_data),
        .ex_wreg       (ex_wreg),
        .ex_regwrite   (ex_regwrite),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_wreg       (wb_wreg),
        .wb_regwrite   (wb_regwrite),
        .exc_ovf       (exc_ovf),
        .exc_addr      (exc_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  wreg;
        logic        rw;
        logic        ovf;
        logic        aexc;
        logic        chk_data;
        logic        is_mem;
        int          exp_cyc;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          dly;
        bit          hold;
    } rq_t;

    wb_t wb_q[$];
    rq_t rq_q[$];
    int  ack_q[$];

    localparam int BASE = 32'h100;
    logic [7:0]  ref_mem[512];
    logic [31:0] resp_mem[128];
    bit          force_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] wr,
                         input logic rw, input logic ochk, input logic ov,
                         input int dly, input bit hold);
        int n;
        int sz;
        int ea;
        bit st;
        bit exc;
        wb_t e;
        rq_t r;
        logic [31:0] val;
        n = 0;
        while (!ex_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ex_ready) begin
            chk("ready_timeout", {31'h0, ex_ready}, 32'h1);
            return;
        end
        ex_mem_op     = op;
        ex_alures     = a;
        ex_store_data = sd;
        ex_wreg       = wr;
        ex_regwrite   = rw;
        ex_ovf_chk    = ochk;
        ex_overflow   = ov;
        ex_valid      = 1'b1;
        if (op == 1 || op == 6) sz = 4;
        else if (op == 2 || op == 3 || op == 7) sz = 2;
        else if (op == 4 || op == 5 || op == 8) sz = 1;
        else sz = 0;
        st = (op >= 6 && op <= 8);
        e.wreg = wr;
        e.ovf = 1'b0;
        e.aexc = 1'b0;
        e.chk_data = 1'b1;
        e.is_mem = 1'b0;
        e.exp_cyc = cyc + 1;
        exc = 1'b0;
        if (sz == 0) begin
            e.data = a;
            e.ovf = ochk & ov;
            e.rw = rw & !(ochk & ov);
            wb_q.push_back(e);
        end else begin
`ifdef MEM_ALIGN_EXC_EN
            if ((a % sz) != 0) begin
                exc = 1'b1;
                e.data = a;
                e.rw = 1'b0;
                e.aexc = 1'b1;
                wb_q.push_back(e);
            end
`endif
            if (!exc) begin
                ea = int'(a) - (int'(a) % sz);
                r.addr = ea & ~32'h3;
                r.be = 4'b0;
                for (int k = 0; k < sz; k++) r.be[(ea % 4) + k] = 1'b1;
                r.we = st;
                for (int j = 0; j < 4; j++)
                    r.wdata[8*j +: 8] = sd[8*(j % sz) +: 8];
                r.dly = dly;
                r.hold = hold;
                e.is_mem = 1'b1;
                if (st) begin
                    for (int k = 0; k < sz; k++)
                        ref_mem[ea - BASE + k] = sd[8*k +: 8];
                    e.chk_data = 1'b0;
                    e.rw = 1'b0;
                    e.data = 32'h0;
                end else begin
                    val = 32'h0;
                    for (int k = 0; k < sz; k++)
                        val[8*k +: 8] = ref_mem[ea - BASE + k];
                    if (op == 2 && val[15]) val = val | 32'hFFFF_0000;
                    if (op == 4 && val[7]) val = val | 32'hFFFF_FF00;
                    e.data = val;
                    e.rw = rw;
                end
                rq_q.push_back(r);
                if (!hold) wb_q.push_back(e);
            end
        end
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    // memory responder
    initial begin
        rq_t r;
        int n;
        int w;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                dmem_ack = 1'b1;
                @(negedge clk);
                dmem_ack = 1'b0;
                force_ack = 1'b0;
            end else if (dmem_req) begin
                if (rq_q.size() == 0) begin
                    chk("unexpected_req", {31'h0, dmem_req}, 32'h0);
                    r.addr = dmem_addr;
                    r.be = dmem_be;
                    r.we = dmem_we;
                    r.wdata = dmem_wdata;
                    r.dly = 0;
                    r.hold = 1'b0;
                end else begin
                    r = rq_q.pop_front();
                    chk("req_addr", dmem_addr, r.addr);
                    chk("req_be", {28'h0, dmem_be}, {28'h0, r.be});
                    chk("req_we", {31'h0, dmem_we}, {31'h0, r.we});
                    if (r.we) chk("req_wdata", dmem_wdata, r.wdata);
                end
                if (r.hold) begin
                    n = 0;
                    while (dmem_req && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    for (int i = 0; i < r.dly; i++) begin
                        chk("ready_in_access", {31'h0, ex_ready}, 32'h0);
                        @(negedge clk);
                    end
                    chk("req_held", {31'h0, dmem_req}, 32'h1);
                    chk("addr_stable", dmem_addr, r.addr);
                    w = (int'(dmem_addr) - BASE) >>> 2;
                    if (w >= 0 && w < 128) begin
                        dmem_rdata = resp_mem[w];
                        if (dmem_we)
                            for (int b = 0; b < 4; b++)
                                if (dmem_be[b])
                                    resp_mem[w][8*b +: 8] = dmem_wdata[8*b +: 8];
                    end else begin
                        dmem_rdata = 32'h0;
                    end
                    dmem_ack = 1'b1;
                    ack_q.push_back(cyc);
                    @(negedge clk);
                    dmem_ack = 1'b0;
                    dmem_rdata = $urandom;
                end
            end
        end
    end

    // writeback monitor
    initial begin
        wb_t e;
        int ec;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_wb", {31'h0, wb_valid}, 32'h0);
                end else begin
                    e = wb_q.pop_front();
                    if (e.is_mem) ec = (ack_q.size() != 0) ? ack_q.pop_front() + 1 : -1;
                    else ec = e.exp_cyc;
                    chk("wb_cycle", cyc, ec);
                    chk("wb_wreg", {27'h0, wb_wreg}, {27'h0, e.wreg});
                    chk("wb_regwrite", {31'h0, wb_regwrite}, {31'h0, e.rw});
                    chk("exc_ovf", {31'h0, exc_ovf}, {31'h0, e.ovf});
                    chk("exc_addr", {31'h0, exc_addr}, {31'h0, e.aexc});
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                end
            end else if (exc_ovf || exc_addr) begin
                chk("exc_without_wb", {30'h0, exc_ovf, exc_addr}, 32'h0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        logic [3:0]  op;
        logic        nn;
        int          n;
        rst = 1'b1;
        ex_valid = 1'b0;
        ex_alures = 32'h0;
        ex_overflow = 1'b0;
        ex_ovf_chk = 1'b0;
        ex_mem_op = 4'h0;
        ex_store_data = 32'h0;
        ex_wreg = 5'h0;
        ex_regwrite = 1'b0;
        for (int i = 0; i < 128; i++) begin
            w = (i == 0) ? 32'h80FF_FF7F : $urandom;
            resp_mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, ex_ready}, 32'h0);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_we", {31'h0, dmem_we}, 32'h0);
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_exc", {30'h0, exc_ovf, exc_addr}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, ex_ready}, 32'h1);

        issue(4'd0, 32'h0000_1234, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        issue(4'd0, 32'h0000_5678, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        issue(4'd0, 32'hDEAD_0001, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        issue(4'd0, 32'h8000_0000, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        issue(4'd4, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 3, 1'b0);
        issue(4'd7, 32'h0000_0202, 32'h0000_BEEF, 5'd8, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        issue(4'd1, 32'h0000_0101, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        issue(4'd2, 32'h0000_0202, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        issue(4'd3, 32'h0000_0202, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        issue(4'd12, 32'h0000_0ABC, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            nn = !(op >= 1 && op <= 8);
            issue(op, BASE + $urandom_range(0, 511), $urandom,
                  5'($urandom), 1'($urandom), nn & 1'($urandom),
                  1'($urandom), $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 7) == 0) @(negedge clk);
        end

        n = 0;
        while ((wb_q.size() != 0 || dmem_req) && n < 200) begin
            @(negedge clk);
            n++;
        end

        issue(4'd1, 32'h0000_0108, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        n = 0;
        while (!dmem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_req_seen", {31'h0, dmem_req}, 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_mid_ready", {31'h0, ex_ready}, 32'h0);
        chk("rst_mid_wb", {31'h0, wb_valid}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        force_ack = 1'b1;
        repeat (5) @(negedge clk);
        chk("stray_ack_req", {31'h0, dmem_req}, 32'h0);
        chk("stray_ack_ready", {31'h0, ex_ready}, 32'h1);
        chk("queue_empty", wb_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
